// File: rtl/vec_enc_serializer.sv
// Multi-hot to index serializer: latches one request vector and emits the index
// of each set bit, lowest first, one per output handshake.
module vec_enc_serializer #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         busy
);

   // state  | meaning
   // S_IDLE | nothing pending; vector accepted when in_valid
   // S_SEND | pending bits remain; lowest one presented on out_idx
   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [N-1:0]   r_pend;
   logic [N-1:0]   w_pend_nxt;
   logic [N-1:0]   w_pend_drop;
   logic [W-1:0]   w_low_idx;
   logic           w_single;

   // Clearing the lowest set bit also tells us whether it was the only one.
   assign w_pend_drop = r_pend & (r_pend - N'(1));
   assign w_single    = (r_pend != '0) && (w_pend_drop == '0);
   assign busy        = (r_pend != '0);

   always_comb begin
      w_low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_low_idx = W'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_idx     = '0;
      out_last    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_pend_nxt = in_vec;
               if (in_vec != '0) begin
                  w_state_nxt = S_SEND;
               end
            end
         end
         S_SEND: begin
            out_valid = 1'b1;
            out_idx   = w_low_idx;
            out_last  = w_single;
            if (out_ready) begin
               w_pend_nxt = w_pend_drop;
               if (w_single) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_pend_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

endmodule

// File: doc/vec_enc_serializer.md
VEC_ENC_SERIALIZER -- requirements
Module: vec_enc_serializer

Interface
REQ-001 Parameter N, default 16, is the width of the request vector.
REQ-002 Parameter W, default 4, is the index width, and W SHALL equal clog2(N).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  producer is presenting a request vector.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 in_vec  input  N  multi-hot request vector; any number of bits may be set.
REQ-008 out_valid  output  1  out_idx holds a valid index.
REQ-009 out_ready  input  1  consumer accepts the current index.
REQ-010 out_idx  output  W  binary index of one set bit of the latched vector.
REQ-011 out_last  output  1  the current index is the final one for the latched vector.
REQ-012 busy  output  1  a latched vector still has unsent bits.

Function
REQ-013 Purpose: convert one multi-hot vector into a stream of binary indices, one per handshake. This is the sequential counterpart of the one-hot encoder, lifting its single-bit restriction.
REQ-014 There SHALL be two states:
- IDLE: pend == 0.
- SEND: pend != 0.
- pend is an N-bit register.
REQ-015 in_ready SHALL be 1 exactly in IDLE and 0 in SEND.
REQ-016 Input accept occurs when in_valid && in_ready; pend SHALL load in_vec on that edge.
REQ-017 An accepted in_vec == 0 SHALL be consumed with no output beat; the state SHALL remain IDLE and in_ready SHALL stay 1.
REQ-018 Accepting a nonzero vector SHALL move the state to SEND; out_valid SHALL be 1 in the next cycle (one-cycle latency from accept).
REQ-019 In SEND, out_valid = 1 and out_idx = index of the lowest-numbered set bit of pend. Ordering SHALL be ascending.
REQ-020 out_last SHALL be 1 in SEND exactly when pend has a single set bit.
REQ-021 Output beat occurs when out_valid && out_ready; that bit of pend SHALL clear on the edge.
REQ-022 While out_ready = 0, out_valid, out_idx and out_last SHALL hold stable.
REQ-023 When the last beat (out_last = 1) handshakes, the state SHALL move to IDLE and in_ready SHALL be 1 in the next cycle. There is one bubble cycle between vectors; there is no same-cycle re-accept.
REQ-024 in_vec and in_valid SHALL be ignored in SEND; a pending vector SHALL never be altered by input activity.
REQ-025 A vector with k set bits SHALL produce exactly k beats, each index exactly once; the maximum is N beats.
REQ-026 busy SHALL equal (pend != 0).
REQ-027 In IDLE, out_valid and out_last SHALL be 0; out_idx SHALL be 0.

Reset
REQ-028 rst_n low SHALL immediately clear pend to 0, forcing IDLE.
REQ-029 Reset values: in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, busy = 0.
REQ-030 Reset asserted mid-SEND SHALL abandon the remaining indices; none SHALL be emitted after release.
REQ-031 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-032 Reset with out_ready = 1, then in_vec = 16'h0001 -> one beat: out_idx = 0, out_last = 1; in_ready = 1 on the following cycle.
REQ-033 in_vec = 16'hA412, out_ready = 1 constantly -> beats out_idx = 1, 4, 10, 13, 15 on consecutive cycles, out_last only on 15.
REQ-034 in_vec = 16'hFFFF with out_ready toggling 1,0,1,0 -> 16 beats 0..15 in order; outputs hold during the 0 cycles; out_last only with idx 15.
REQ-035 in_vec = 16'h0000 with in_valid = 1 -> no out_valid; in_ready stays 1; the next vector 16'h8000 gives a single beat idx = 15, out_last = 1.
REQ-036 Accept 16'h00F0, complete one beat (idx = 4), then pulse rst_n low -> all outputs reset immediately; no idx 5..7 appears after release.
REQ-037 During SEND of 16'h0300, drive in_valid = 1 with in_vec = 16'h0001 -> that input is not accepted; the output is idx 8, then 9 (last); 16'h0001 is accepted only after in_ready returns to 1.
